// File: rtl/cdb_arbiter_pkg.sv
// System-wide FU counts and CDB sizing shared by the arbiter, its picker and its interface.
// Also holds the small index-width helper they all use.
package cdb_arbiter_pkg;

    localparam int CFG_CDB_N          = 3;
    localparam int CFG_NUM_FU_ALU     = 3;
    localparam int CFG_NUM_FU_BRANCH  = 1;
    localparam int CFG_NUM_FU_MULT    = 2;
    localparam int CFG_LOAD_BUFFER_SZ = 4;

    localparam int NUM_FU_TOTAL = CFG_LOAD_BUFFER_SZ + CFG_NUM_FU_MULT +
                                  CFG_NUM_FU_ALU + CFG_NUM_FU_BRANCH;
    localparam int NUM_FU_STALL = CFG_NUM_FU_MULT + CFG_LOAD_BUFFER_SZ;

    localparam int CDB_STARVE_LIMIT = 4;

    // Index width that stays legal (>=1) for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request / CDB grant bundle between the functional units and the CDB arbiter.
// master = request side, slave = arbiter side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N         = CFG_CDB_N,
    parameter int NUM_TOTAL = NUM_FU_TOTAL,
    parameter int NUM_MULT  = CFG_NUM_FU_MULT,
    parameter int NUM_LOAD  = CFG_LOAD_BUFFER_SZ
);

    logic [NUM_TOTAL-1:0]        fu_req;
    logic [N-1:0][NUM_TOTAL-1:0] complete_gnt_bus;
    logic [NUM_MULT-1:0]         mult_cdb_gnt;
    logic [NUM_LOAD-1:0]         load_cdb_gnt;
    logic                        fixed_overflow;

    modport master (
        output fu_req,
        input  complete_gnt_bus,
        input  mult_cdb_gnt,
        input  load_cdb_gnt,
        input  fixed_overflow
    );

    modport slave (
        input  fu_req,
        output complete_gnt_bus,
        output mult_cdb_gnt,
        output load_cdb_gnt,
        output fixed_overflow
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin multi-pick: walks the request vector from i_start (wrapping) and grants
// up to i_avail requesters; o_last is the final index granted in walk order.
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int MAX_PICKS = 3,
    localparam int PW = idx_width(WIDTH),
    localparam int AW = $clog2(MAX_PICKS + 1)
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [PW-1:0]    i_start,
    input  logic [AW-1:0]    i_avail,
    output logic [WIDTH-1:0] o_gnt,
    output logic [PW-1:0]    o_last
);

    always_comb begin
        int cnt;
        int idx;
        o_gnt  = '0;
        o_last = '0;
        cnt    = 0;
        idx    = 0;
        for (int j = 0; j < WIDTH; j++) begin
            idx = (int'(i_start) + j) % WIDTH;
            if (i_req[PW'(idx)] && cnt < int'(i_avail)) begin
                o_gnt[PW'(idx)] = 1'b1;
                o_last          = PW'(idx);
                cnt++;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: zero-latency assignment of up to N completion slots per cycle.
// Fixed FUs (branch, ALU) first, then starved stallable FUs, then round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N              = CFG_CDB_N,
    parameter int NUM_FU_ALU     = CFG_NUM_FU_ALU,
    parameter int NUM_FU_BRANCH  = CFG_NUM_FU_BRANCH,
    parameter int NUM_FU_MULT    = CFG_NUM_FU_MULT,
    parameter int LOAD_BUFFER_SZ = CFG_LOAD_BUFFER_SZ,
    parameter int STARVE_LIMIT   = CDB_STARVE_LIMIT
) (
    input logic          clock,
    input logic          reset,
    cdb_arbiter_if.slave cdb
);

    localparam int NTOT   = LOAD_BUFFER_SZ + NUM_FU_MULT + NUM_FU_ALU + NUM_FU_BRANCH;
    localparam int NSTALL = NUM_FU_MULT + LOAD_BUFFER_SZ;
    localparam int PW     = idx_width(NSTALL);
    localparam int TIW    = idx_width(NTOT);
    localparam int SIW    = idx_width(N);
    localparam int SW     = $clog2(N + 1);
    localparam int CW     = $clog2(STARVE_LIMIT + 1);

    logic [NSTALL-1:0][CW-1:0] r_starve_cnt;
    logic [PW-1:0]             r_rr_ptr;

    logic [NSTALL-1:0]         w_stall_req;
    logic [NSTALL-1:0]         w_starved;
    logic [NSTALL-1:0]         w_rr_req;
    logic [NSTALL-1:0]         w_rr_gnt;
    logic [NSTALL-1:0]         w_stall_gnt;
    logic [PW-1:0]             w_rr_last;
    logic [N-1:0][NTOT-1:0]    w_pri_bus;
    logic [N-1:0][NTOT-1:0]    w_gnt_bus;
    logic [SW-1:0]             w_pri_used;
    logic [SW-1:0]             w_rr_avail;
    logic                      w_fixed_ovf;

    assign w_stall_req = cdb.fu_req[NSTALL-1:0];

    always_comb begin
        for (int k = 0; k < NSTALL; k++) begin
            w_starved[k] = w_stall_req[k] && (r_starve_cnt[k] == CW'(STARVE_LIMIT));
        end
    end

    assign w_rr_req = w_stall_req & ~w_starved;

    // Fixed requesters from the top index down, then starved stallables in ascending order.
    always_comb begin
        int slot;
        int nfix;
        w_pri_bus = '0;
        slot      = 0;
        nfix      = 0;
        for (int i = NTOT - 1; i >= NSTALL; i--) begin
            if (cdb.fu_req[i]) begin
                nfix++;
                if (slot < N) begin
                    w_pri_bus[SIW'(slot)][i] = 1'b1;
                    slot++;
                end
            end
        end
        w_fixed_ovf = (nfix > N);
        for (int k = 0; k < NSTALL; k++) begin
            if (w_starved[k] && slot < N) begin
                w_pri_bus[SIW'(slot)][k] = 1'b1;
                slot++;
            end
        end
        w_pri_used = SW'(slot);
        w_rr_avail = SW'(N - slot);
    end

    rr_picker #(
        .WIDTH     (NSTALL),
        .MAX_PICKS (N)
    ) u_rr_picker (
        .i_req   (w_rr_req),
        .i_start (r_rr_ptr),
        .i_avail (w_rr_avail),
        .o_gnt   (w_rr_gnt),
        .o_last  (w_rr_last)
    );

    // Round-robin winners take the next free slots in the order the picker walked them.
    always_comb begin
        int slot;
        int k;
        w_gnt_bus = w_pri_bus;
        slot      = int'(w_pri_used);
        k         = 0;
        for (int j = 0; j < NSTALL; j++) begin
            k = (int'(r_rr_ptr) + j) % NSTALL;
            if (w_rr_gnt[PW'(k)] && slot < N) begin
                w_gnt_bus[SIW'(slot)][TIW'(k)] = 1'b1;
                slot++;
            end
        end
    end

    always_comb begin
        w_stall_gnt = '0;
        for (int s = 0; s < N; s++) begin
            w_stall_gnt = w_stall_gnt | w_gnt_bus[s][NSTALL-1:0];
        end
    end

    assign cdb.complete_gnt_bus = reset ? '0 : w_gnt_bus;
    assign cdb.fixed_overflow   = !reset && w_fixed_ovf;
    assign cdb.load_cdb_gnt     = reset ? '0 : w_stall_gnt[LOAD_BUFFER_SZ-1:0];
    assign cdb.mult_cdb_gnt     = reset ? '0 : w_stall_gnt[NSTALL-1:LOAD_BUFFER_SZ];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (|w_rr_gnt) begin
                r_rr_ptr <= (w_rr_last == PW'(NSTALL - 1)) ? '0 : w_rr_last + 1'b1;
            end
            for (int k = 0; k < NSTALL; k++) begin
                if (w_stall_gnt[k] || !w_stall_req[k]) begin
                    r_starve_cnt[k] <= '0;
                end else if (r_starve_cnt[k] != CW'(STARVE_LIMIT)) begin
                    r_starve_cnt[k] <= r_starve_cnt[k] + 1'b1;
                end
            end
        end
    end

endmodule
